// File: rtl/fetch_pkg.sv
// Shared fetch-side types and constants for the program counter sequencer.
package fetch_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    // Sequencer states
    typedef enum logic [1:0] {
        BOOT,
        REQ,
        WAIT,
        HOLD
    } fetch_state_t;

    // Source selected for the next program counter value
    typedef enum logic [1:0] {
        PC_SEL_RESET,
        PC_SEL_TARGET,
        PC_SEL_INC,
        PC_SEL_HOLD
    } pc_sel_t;

    // Instructions are word aligned, so redirect targets drop their low two bits
    function automatic logic [XLEN-1:0] align_target(input logic [XLEN-1:0] t);
        return {t[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundles the instruction-memory handshake, decode hand-off and redirect inputs.
interface pc_sequencer_if;
    import fetch_pkg::*;

    // Instruction-memory request / response
    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_instr;

    // Decode hand-off
    logic            fetch_valid;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] fetch_instr;
    logic            dec_stall;

    // Redirect sources
    logic            br_taken;
    logic [XLEN-1:0] br_target;
    logic            trap;
    logic [XLEN-1:0] trap_vec;
    logic            mret;
    logic [XLEN-1:0] mepc;
    logic            target_misaligned;

    // Sequencer side
    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_instr,
        output fetch_valid, fetch_pc, fetch_instr,
        input  dec_stall,
        input  br_taken, br_target, trap, trap_vec, mret, mepc,
        output target_misaligned
    );

    // Memory / decode / control side
    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_instr,
        input  fetch_valid, fetch_pc, fetch_instr,
        output dec_stall,
        output br_taken, br_target, trap, trap_vec, mret, mepc,
        input  target_misaligned
    );

endinterface

// File: rtl/pc_sequencer_pc_reg.sv
// Program counter register: loads pc_in every cycle, resets to RESET_VAL.
module pc_reg
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VAL = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_in,
    output logic [XLEN-1:0] pc_out
);

    logic [XLEN-1:0] r_pc;

    // PC storage; the sequencer feeds back pc_out when it wants to hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_VAL;
        end else begin
            r_pc <= pc_in;
        end
    end

    assign pc_out = r_pc;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch sequencer: issues one instruction-memory request at a time, hands
// responses to decode (buffering across decode stalls) and applies
// trap / mret / branch redirects, squashing any in-flight response.
module pc_sequencer
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    pc_sequencer_if.master  bus
);

    fetch_state_t    r_state;
    fetch_state_t    w_state_next;
    logic            r_kill;
    logic            w_kill_next;
    logic [XLEN-1:0] r_buf_instr;
    logic [XLEN-1:0] w_buf_instr_next;

    pc_sel_t         w_pc_sel;
    logic [XLEN-1:0] w_pc;
    logic [XLEN-1:0] w_pc_in;
    logic [XLEN-1:0] w_pc_inc;

    logic            w_redir;
    logic [XLEN-1:0] w_target_raw;
    logic [XLEN-1:0] w_target;

    // Redirect selection: trap beats mret beats branch; nothing redirects in BOOT
    always_comb begin
        w_redir = 1'b0;
        if (r_state != BOOT) begin
            w_redir = bus.trap | bus.mret | bus.br_taken;
        end
        if (bus.trap) begin
            w_target_raw = bus.trap_vec;
        end else if (bus.mret) begin
            w_target_raw = bus.mepc;
        end else begin
            w_target_raw = bus.br_target;
        end
        w_target = align_target(w_target_raw);
    end

    // Sequential increment wraps naturally at 2^32
    assign w_pc_inc = w_pc + XLEN'(INSTR_BYTES);

    // Next PC source
    always_comb begin
        case (w_pc_sel)
            PC_SEL_RESET:  w_pc_in = RESET_VEC;
            PC_SEL_TARGET: w_pc_in = w_target;
            PC_SEL_INC:    w_pc_in = w_pc_inc;
            default:       w_pc_in = w_pc;
        endcase
    end

    pc_reg #(
        .RESET_VAL (RESET_VEC)
    ) u_pc_reg (
        .clk    (clk),
        .rst    (rst),
        .pc_in  (w_pc_in),
        .pc_out (w_pc)
    );

    // State, kill flag and stall buffer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= BOOT;
            r_kill      <= 1'b0;
            r_buf_instr <= '0;
        end else begin
            r_state     <= w_state_next;
            r_kill      <= w_kill_next;
            r_buf_instr <= w_buf_instr_next;
        end
    end

    // Next-state, kill and PC-source decisions
    always_comb begin
        w_state_next     = r_state;
        w_kill_next      = r_kill;
        w_buf_instr_next = r_buf_instr;
        w_pc_sel         = PC_SEL_HOLD;
        case (r_state)
            BOOT: begin
                w_pc_sel     = PC_SEL_RESET;
                w_kill_next  = 1'b0;
                w_state_next = REQ;
            end
            REQ: begin
                if (bus.imem_req_ready) begin
                    w_state_next = WAIT;
                    if (w_redir) begin
                        // Request already accepted at the old PC: squash its response
                        w_kill_next = 1'b1;
                        w_pc_sel    = PC_SEL_TARGET;
                    end
                end else if (w_redir) begin
                    w_pc_sel = PC_SEL_TARGET;
                end
            end
            WAIT: begin
                if (bus.imem_rsp_valid) begin
                    if (r_kill) begin
                        w_kill_next  = 1'b0;
                        w_state_next = REQ;
                        if (w_redir) begin
                            w_pc_sel = PC_SEL_TARGET;
                        end
                    end else if (w_redir) begin
                        w_state_next = REQ;
                        w_pc_sel     = PC_SEL_TARGET;
                    end else if (!bus.dec_stall) begin
                        w_state_next = REQ;
                        w_pc_sel     = PC_SEL_INC;
                    end else begin
                        w_buf_instr_next = bus.imem_rsp_instr;
                        w_state_next     = HOLD;
                    end
                end else if (w_redir) begin
                    // Response still in flight; retarget now and drop it on arrival
                    w_kill_next = 1'b1;
                    w_pc_sel    = PC_SEL_TARGET;
                end
            end
            HOLD: begin
                if (w_redir) begin
                    w_state_next = REQ;
                    w_pc_sel     = PC_SEL_TARGET;
                end else if (!bus.dec_stall) begin
                    w_state_next = REQ;
                    w_pc_sel     = PC_SEL_INC;
                end
            end
            default: begin
                w_state_next = BOOT;
            end
        endcase
    end

    // Outputs; all forced to their idle values while reset is asserted
    always_comb begin
        bus.imem_req_valid    = 1'b0;
        bus.imem_req_addr     = '0;
        bus.fetch_valid       = 1'b0;
        bus.fetch_pc          = '0;
        bus.fetch_instr       = '0;
        bus.target_misaligned = 1'b0;
        if (!rst) begin
            bus.imem_req_addr     = w_pc;
            bus.fetch_pc          = w_pc;
            bus.fetch_instr       = r_buf_instr;
            bus.target_misaligned = w_redir && (w_target_raw[1:0] != 2'b00);
            case (r_state)
                REQ: begin
                    bus.imem_req_valid = 1'b1;
                end
                WAIT: begin
                    if (bus.imem_rsp_valid) begin
                        bus.fetch_instr = bus.imem_rsp_instr;
                        bus.fetch_valid = !r_kill && !w_redir;
                    end
                end
                HOLD: begin
                    bus.fetch_valid = !w_redir;
                end
                default: begin
                    bus.fetch_valid = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a one-cycle-latency instruction memory.
module tb_pc_sequencer;
    import fetch_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_sequencer_if bus();

    pc_sequencer #(
        .RESET_VEC (32'h0000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic        pend     = 1'b0;
    logic        hold_rsp = 1'b0;
    logic [31:0] paddr    = '0;

    // Memory contents: a recognisable word derived from the address
    function automatic logic [31:0] io(input logic [31:0] a);
        return 32'hABCD_0000 ^ a;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // One clock: record acceptance, advance, then present any due response
    task automatic clk_cyc();
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            pend  = 1'b1;
            paddr = bus.imem_req_addr;
        end
        @(posedge clk);
        #1;
        if (pend && !hold_rsp) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_instr = io(paddr);
            pend               = 1'b0;
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_instr = 32'hDEAD_BEEF;
        end
        #1;
    endtask

    task automatic clear_redir();
        bus.br_taken = 1'b0;
        bus.trap     = 1'b0;
        bus.mret     = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clk_cyc();
        clk_cyc();
        #1;
        check("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
        check("rst_req_addr", bus.imem_req_addr, 32'h0);
        check("rst_fetch_valid", 32'(bus.fetch_valid), 32'h0);
        check("rst_fetch_pc", bus.fetch_pc, 32'h0);
        check("rst_fetch_instr", bus.fetch_instr, 32'h0);
        check("rst_misaligned", 32'(bus.target_misaligned), 32'h0);
        rst = 1'b0;
        #1;
        check("boot_req_valid", 32'(bus.imem_req_valid), 32'h0);
    endtask

    // Request expected this cycle at the given address
    task automatic expect_req(input string tag, input logic [31:0] addr);
        #1;
        check({tag, "_valid"}, 32'(bus.imem_req_valid), 32'h1);
        check({tag, "_addr"}, bus.imem_req_addr, addr);
    endtask

    // Instruction expected at decode this cycle
    task automatic expect_fetch(input string tag, input logic [31:0] pc);
        #1;
        check({tag, "_fv"}, 32'(bus.fetch_valid), 32'h1);
        check({tag, "_pc"}, bus.fetch_pc, pc);
        check({tag, "_instr"}, bus.fetch_instr, io(pc));
    endtask

    initial begin
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_instr = '0;
        bus.dec_stall      = 1'b0;
        bus.br_taken       = 1'b0;
        bus.br_target      = '0;
        bus.trap           = 1'b0;
        bus.trap_vec       = '0;
        bus.mret           = 1'b0;
        bus.mepc           = '0;

        // Run A: straight-line fetch, requests on cycles 2, 4, 6
        do_reset();
        clk_cyc(); expect_req("a_c2_req0", 32'h0);
        clk_cyc(); expect_fetch("a_c3_rsp0", 32'h0);
        check("a_c3_no_req", 32'(bus.imem_req_valid), 32'h0);
        clk_cyc(); expect_req("a_c4_req4", 32'h4);
        clk_cyc(); expect_fetch("a_c5_rsp4", 32'h4);
        clk_cyc(); expect_req("a_c6_req8", 32'h8);

        // Run B: stall, redirects, reset mid-request, wrap
        do_reset();
        clk_cyc(); expect_req("b_req0", 32'h0);
        clk_cyc(); expect_fetch("b_rsp0", 32'h0);
        clk_cyc(); expect_req("b_req4", 32'h4);
        clk_cyc(); bus.dec_stall = 1'b1; expect_fetch("b_stall1", 32'h4);
        clk_cyc(); expect_fetch("b_stall2", 32'h4);
        check("b_hold_no_req", 32'(bus.imem_req_valid), 32'h0);
        clk_cyc(); expect_fetch("b_stall3", 32'h4);
        clk_cyc(); bus.dec_stall = 1'b0; expect_fetch("b_release", 32'h4);
        clk_cyc(); expect_req("b_req8", 32'h8);

        // Branch while waiting for 0x8; late response must be dropped
        hold_rsp = 1'b1;
        clk_cyc();
        bus.br_taken = 1'b1; bus.br_target = 32'h100; #1;
        check("b_br_fv", 32'(bus.fetch_valid), 32'h0);
        check("b_br_misal", 32'(bus.target_misaligned), 32'h0);
        hold_rsp = 1'b0;
        clk_cyc(); clear_redir(); #1;
        check("b_killed_fv", 32'(bus.fetch_valid), 32'h0);
        check("b_killed_no_req", 32'(bus.imem_req_valid), 32'h0);
        clk_cyc(); expect_req("b_req100", 32'h100);
        clk_cyc(); expect_fetch("b_rsp100", 32'h100);

        // Trap and branch together while memory is not ready
        clk_cyc();
        bus.imem_req_ready = 1'b0;
        bus.trap = 1'b1; bus.trap_vec = 32'h200;
        bus.br_taken = 1'b1; bus.br_target = 32'h100;
        expect_req("b_req104_pre", 32'h104);
        clk_cyc(); clear_redir(); expect_req("b_req200", 32'h200);
        clk_cyc(); expect_req("b_req200_stable", 32'h200);
        bus.imem_req_ready = 1'b1;
        clk_cyc(); expect_fetch("b_rsp200", 32'h200);

        // mret to a misaligned mepc, redirected as the request is accepted
        clk_cyc();
        bus.mret = 1'b1; bus.mepc = 32'h302;
        #1;
        check("b_mret_misal", 32'(bus.target_misaligned), 32'h1);
        check("b_mret_addr", bus.imem_req_addr, 32'h204);
        clk_cyc(); clear_redir(); #1;
        check("b_mret_misal_off", 32'(bus.target_misaligned), 32'h0);
        check("b_mret_killed_fv", 32'(bus.fetch_valid), 32'h0);
        clk_cyc(); expect_req("b_req300", 32'h300);
        clk_cyc(); expect_fetch("b_rsp300", 32'h300);
        clk_cyc(); expect_req("b_req304", 32'h304);

        // Reset while waiting; the stale response lands during BOOT
        hold_rsp = 1'b1;
        clk_cyc();
        rst = 1'b1; #1;
        check("b_rst_wait_fv", 32'(bus.fetch_valid), 32'h0);
        check("b_rst_wait_req", 32'(bus.imem_req_valid), 32'h0);
        hold_rsp = 1'b0;
        clk_cyc();
        rst = 1'b0; #1;
        check("b_stale_rsp_seen", 32'(bus.imem_rsp_valid), 32'h1);
        check("b_stale_fv", 32'(bus.fetch_valid), 32'h0);
        check("b_stale_no_req", 32'(bus.imem_req_valid), 32'h0);
        check("b_stale_instr", bus.fetch_instr, 32'h0);
        clk_cyc(); expect_req("b_req_resetvec", 32'h0);
        clk_cyc(); expect_fetch("b_rsp_resetvec", 32'h0);

        // Branch to the last word; next sequential fetch wraps to zero
        clk_cyc();
        bus.br_taken = 1'b1; bus.br_target = 32'hFFFF_FFFC;
        expect_req("b_req4_again", 32'h4);
        clk_cyc(); clear_redir(); #1;
        check("b_wrap_killed_fv", 32'(bus.fetch_valid), 32'h0);
        clk_cyc(); expect_req("b_req_top", 32'hFFFF_FFFC);
        clk_cyc(); expect_fetch("b_rsp_top", 32'hFFFF_FFFC);
        clk_cyc(); expect_req("b_req_wrap", 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-side controller that owns and sequences the program counter register. It issues instruction-memory requests over a valid/ready handshake and delivers fetched instructions to decode. It also applies redirects: branch/jump, trap entry and mret. It sits between the PC register, instruction memory and the decode stage of the 32-bit RISC-V core.

## Interface
- RESET_VEC, 32'h0000_0000, first fetch address after reset
- clk  in  1  core clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  32  fetch address (current PC)
- imem_req_ready  in  1  memory accepts request
- imem_rsp_valid  in  1  response valid, single-cycle pulse
- imem_rsp_instr  in  32  response instruction word
- fetch_valid  out  1  instruction available to decode
- fetch_pc  out  32  PC of fetch_instr
- fetch_instr  out  32  instruction to decode
- dec_stall  in  1  decode cannot accept this cycle
- br_taken  in  1  branch/jump redirect
- br_target  in  32  branch target
- trap  in  1  trap entry
- trap_vec  in  32  trap handler address (mtvec)
- mret  in  1  return from trap
- mepc  in  32  return address
- target_misaligned  out  1  pulse: selected redirect target had bits[1:0] != 0

## Operation
- States: BOOT, REQ, WAIT, HOLD. Internal kill flag; 32-bit instruction buffer.
- Redirect priority: trap > mret > br_taken. Selected target has bits[1:0] forced to 0. target_misaligned pulses the same cycle if the original bits were nonzero.
- Any redirect forces fetch_valid = 0 that cycle and loads the PC with the target next cycle.
- BOOT: PC loads RESET_VEC, then go to REQ. Redirects are ignored in BOOT.
- REQ: imem_req_valid = 1, imem_req_addr = PC.
  - Ready, no redirect: go to WAIT.
  - Ready with redirect: go to WAIT with kill = 1.
  - No ready, with redirect: stay in REQ with the new address next cycle.
- WAIT: imem_req_valid = 0. Actions on rsp_valid:
  - kill = 1: discard the response, clear kill, go to REQ.
  - kill = 0 and redirect: discard the response, go to REQ at the target.
  - kill = 0, no redirect: fetch_valid = 1, fetch_instr = imem_rsp_instr, fetch_pc = PC.
    - !dec_stall: PC <= PC + 4, go to REQ.
    - dec_stall: capture into the buffer, go to HOLD.
  - Redirect without rsp_valid: set kill = 1, load the target, stay in WAIT.
- HOLD: fetch_valid = 1 from the buffer.
  - !dec_stall: PC <= PC + 4, go to REQ.
  - Redirect: drop the buffer, go to REQ at the target.
- PC + 4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
- rst in any state, including mid-request: go to BOOT. Clear kill, fetch_valid and target_misaligned. Any response arriving later is ignored until the next REQ acceptance.

## Timing
- Reset values: imem_req_valid = 0, imem_req_addr = 0, fetch_valid = 0, fetch_pc = 0, fetch_instr = 0, target_misaligned = 0.
- First request is visible 2 cycles after rst deasserts (BOOT, then REQ).
- fetch_valid, fetch_instr and fetch_pc are combinational from the response in WAIT, and registered in HOLD.
- Peak throughput is 1 instruction per 2 cycles, given ready = 1 and a response one cycle after acceptance.
- imem_req_addr is stable while valid and !ready, except when a redirect occurs.
- Exactly one request is outstanding at any time.

## Structure
- Shared package fetch_pkg holds:
  - typedef enum logic [1:0] {BOOT, REQ, WAIT, HOLD} fetch_state_t
  - localparam XLEN = 32
  - localparam INSTR_BYTES = 4
- Instantiate the existing PC register module (clk, rst, pc_in, pc_out) as the sole sub-module.
  - The sequencer drives pc_in with one of: RESET_VEC, target, PC + 4, or pc_out (hold).

## Test plan
- Reset release, ready = 1, 1-cycle response -> requests at 0x0, 0x4, 0x8 on cycles 2, 4, 6; fetch_pc matches each.
- dec_stall high for 3 cycles on the response for 0x4 -> HOLD; fetch_instr stable for 3 cycles; next request 0x8 after the stall drops.
- br_taken to 0x100 while in WAIT for 0x8 -> response for 0x8 discarded, fetch_valid stays 0; next request 0x100.
- trap (trap_vec = 0x200) and br_taken (0x100) in the same cycle -> next request 0x200.
- mret with mepc = 0x302 -> target_misaligned pulses once; next request 0x300.
- rst asserted in WAIT, stale response arrives during BOOT -> response ignored; first request at RESET_VEC.
